// File: rtl/ts_null_stuffer.sv
// rtl/ts_null_stuffer.sv - constant-rate TS output stage with null-packet stuffing (stats ports: NULL_STUFF_STAT_EN)
module ts_null_stuffer #(
    parameter int PKT_DEPTH = 4
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [7:0]  DATA_IN,
    input  logic        ENA_IN,
    input  logic        PSYNC_IN,
    input  logic        BYTE_STROBE,
    output logic [7:0]  DATA_OUT,
    output logic        ENA_OUT,
    output logic        PSYNC_OUT,
    output logic        OVERFLOW,
    output logic        RUNT
`ifdef NULL_STUFF_STAT_EN
    ,
    output logic [15:0] NULL_CNT,
    output logic [15:0] DROP_CNT
`endif
);
    localparam int PKT_LEN = 188;
    localparam int DEPTH_B = PKT_DEPTH * PKT_LEN;
    localparam int AW      = $clog2(DEPTH_B);
    localparam int UW      = $clog2(DEPTH_B + 1);
    localparam int CW      = $clog2(PKT_DEPTH + 1);
    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH_B - 1);
    localparam logic [UW-1:0] MAX_USED  = UW'(DEPTH_B - PKT_LEN);
    localparam logic [UW-1:0] PKT_LEN_U = UW'(PKT_LEN);
    localparam logic [7:0]    LAST_BYTE = 8'd187;

    typedef enum logic [1:0] {IDLE, SEND_PKT, SEND_NULL} state_t;
    state_t state, state_next;

    logic [7:0]    mem [DEPTH_B];
    logic [AW-1:0] wptr, cptr, rptr, waddr;
    logic [7:0]    wcnt, rcnt;
    logic [UW-1:0] used;
    logic [CW-1:0] pkt_cnt;
    logic [7:0]    ram_q, null_q, null_byte;
    logic          sel_pkt;
    logic          sync_byte, runt_ev, start_ok, ovf_ev, store, commit;
    logic          start_pkt, start_null, rd_en, rd_last;

    // Byte RAM is not a power of two deep, so pointers wrap on an explicit compare.
    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == LAST_ADDR) ? '0 : p + AW'(1);
    endfunction

    // wcnt==0 means no packet is being stored: stray bytes and the tail of a dropped packet are ignored.
    always_comb begin
        sync_byte = ENA_IN && PSYNC_IN;
        runt_ev   = sync_byte && (wcnt != 8'd0);
        start_ok  = sync_byte && (used <= MAX_USED);
        ovf_ev    = sync_byte && !start_ok;
        store     = start_ok || (ENA_IN && !PSYNC_IN && (wcnt != 8'd0));
        commit    = store && !sync_byte && (wcnt == LAST_BYTE);
        waddr     = start_ok ? cptr : wptr;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            wptr     <= '0;
            cptr     <= '0;
            wcnt     <= 8'd0;
            OVERFLOW <= 1'b0;
            RUNT     <= 1'b0;
        end else begin
            OVERFLOW <= ovf_ev;
            RUNT     <= runt_ev;
            if (start_ok) begin
                wptr <= ptr_inc(cptr);
                wcnt <= 8'd1;
            end else if (ovf_ev) begin
                wptr <= cptr;
                wcnt <= 8'd0;
            end else if (store) begin
                wptr <= ptr_inc(wptr);
                wcnt <= commit ? 8'd0 : wcnt + 8'd1;
            end
            if (commit) begin
                cptr <= ptr_inc(wptr);
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (store) begin
            mem[waddr] <= DATA_IN;
        end
    end

    always_comb begin
        state_next = state;
        start_pkt  = 1'b0;
        start_null = 1'b0;
        rd_en      = 1'b0;
        rd_last    = (rcnt == LAST_BYTE);
        null_byte  = 8'hFF;
        case (state)
            IDLE: begin
                if (BYTE_STROBE) begin
                    null_byte = 8'h47;
                    if (pkt_cnt != '0) begin
                        start_pkt  = 1'b1;
                        rd_en      = 1'b1;
                        state_next = SEND_PKT;
                    end else begin
                        start_null = 1'b1;
                        state_next = SEND_NULL;
                    end
                end
            end
            SEND_PKT: begin
                if (BYTE_STROBE) begin
                    rd_en = 1'b1;
                    if (rd_last) state_next = IDLE;
                end
            end
            SEND_NULL: begin
                if (BYTE_STROBE) begin
                    case (rcnt)
                        8'd1:    null_byte = 8'h1F;
                        8'd3:    null_byte = 8'h10;
                        default: null_byte = 8'hFF;
                    endcase
                    if (rd_last) state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Occupancy counts committed bytes not yet read, so space frees one byte per read.
    always_ff @(posedge CLK) begin
        if (RST) begin
            rptr      <= '0;
            rcnt      <= 8'd0;
            pkt_cnt   <= '0;
            used      <= '0;
            ENA_OUT   <= 1'b0;
            PSYNC_OUT <= 1'b0;
            sel_pkt   <= 1'b0;
            null_q    <= 8'h00;
        end else begin
            ENA_OUT   <= BYTE_STROBE;
            PSYNC_OUT <= start_pkt || start_null;
            sel_pkt   <= rd_en;
            null_q    <= (BYTE_STROBE && !rd_en) ? null_byte : 8'h00;
            if (rd_en) begin
                rptr <= ptr_inc(rptr);
            end
            if (BYTE_STROBE) begin
                rcnt <= (state_next == IDLE) ? 8'd0 : rcnt + 8'd1;
            end
            pkt_cnt <= pkt_cnt + CW'(commit) - CW'(start_pkt);
            used    <= used + (commit ? PKT_LEN_U : '0) - UW'(rd_en);
        end
    end

    always_ff @(posedge CLK) begin
        if (rd_en) begin
            ram_q <= mem[rptr];
        end
    end

    assign DATA_OUT = sel_pkt ? ram_q : null_q;

`ifdef NULL_STUFF_STAT_EN
    logic [16:0] drop_sum;
    assign drop_sum = {1'b0, DROP_CNT} + 17'(ovf_ev) + 17'(runt_ev);

    always_ff @(posedge CLK) begin
        if (RST) begin
            NULL_CNT <= 16'h0000;
            DROP_CNT <= 16'h0000;
        end else begin
            if (start_null && (NULL_CNT != 16'hFFFF)) begin
                NULL_CNT <= NULL_CNT + 16'd1;
            end
            DROP_CNT <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
        end
    end
`endif

endmodule

// File: tb/tb_ts_null_stuffer.sv
// tb/tb_ts_null_stuffer.sv - self-checking bench for ts_null_stuffer against a queue-based packet model
`timescale 1ns/1ps
module tb_ts_null_stuffer;
    localparam int PKT_DEPTH = 4;
    localparam int PL = 188;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic [7:0] DATA_IN = 8'h00;
    logic       ENA_IN = 1'b0;
    logic       PSYNC_IN = 1'b0;
    logic       BYTE_STROBE = 1'b0;
    logic [7:0] DATA_OUT;
    logic       ENA_OUT, PSYNC_OUT, OVERFLOW, RUNT;

    ts_null_stuffer #(.PKT_DEPTH(PKT_DEPTH)) dut (
        .CLK(CLK), .RST(RST), .DATA_IN(DATA_IN), .ENA_IN(ENA_IN), .PSYNC_IN(PSYNC_IN),
        .BYTE_STROBE(BYTE_STROBE), .DATA_OUT(DATA_OUT), .ENA_OUT(ENA_OUT),
        .PSYNC_OUT(PSYNC_OUT), .OVERFLOW(OVERFLOW), .RUNT(RUNT)
    );

    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int pkt_byte(input int seed, input int i);
        case (i)
            0: return 'h47;
            1: return 'h40;
            2: return 'h00;
            3: return 'h10;
            default: return (seed + i) & 255;
        endcase
    endfunction

    function automatic int null_ref(input int i);
        case (i)
            0: return 'h47;
            1: return 'h1F;
            3: return 'h10;
            default: return 'hFF;
        endcase
    endfunction

    // Packet-level model: committed packets as a byte queue, output walks whole 188-byte packets.
    byte unsigned stq[$];
    byte unsigned wr_cur[$];
    byte unsigned cur_out[PL];
    int  n_pkts = 0, read_left = 0, rd_idx = 0, occ0 = 0;
    bit  in_wr = 0, rd_is_pkt = 0;
    int  exp_ena = 0, exp_psync = 0, exp_data = 0, exp_ovf = 0, exp_runt = 0;

    initial forever begin
        @(posedge CLK);
        if (RST) begin
            stq.delete(); wr_cur.delete();
            n_pkts = 0; read_left = 0; rd_idx = 0; in_wr = 0; rd_is_pkt = 0;
            exp_ena = 0; exp_psync = 0; exp_data = 0; exp_ovf = 0; exp_runt = 0;
        end else begin
            occ0 = PL * n_pkts + read_left;
            exp_ena = 0; exp_psync = 0; exp_data = 0;
            if (BYTE_STROBE) begin
                if (rd_idx == 0) begin
                    exp_psync = 1;
                    if (n_pkts > 0) begin
                        n_pkts--;
                        rd_is_pkt = 1;
                        read_left = PL;
                        for (int i = 0; i < PL; i++) cur_out[i] = stq.pop_front();
                    end else begin
                        rd_is_pkt = 0;
                        for (int i = 0; i < PL; i++) cur_out[i] = 8'(null_ref(i));
                    end
                end
                exp_ena = 1;
                exp_data = cur_out[rd_idx];
                if (rd_is_pkt) read_left--;
                rd_idx = (rd_idx + 1) % PL;
            end
            exp_ovf = 0; exp_runt = 0;
            if (ENA_IN && PSYNC_IN) begin
                if (in_wr) exp_runt = 1;
                wr_cur.delete();
                if (PKT_DEPTH * PL - occ0 >= PL) begin
                    in_wr = 1;
                    wr_cur.push_back(DATA_IN);
                end else begin
                    in_wr = 0;
                    exp_ovf = 1;
                end
            end else if (ENA_IN && in_wr) begin
                wr_cur.push_back(DATA_IN);
                if (wr_cur.size() == PL) begin
                    foreach (wr_cur[i]) stq.push_back(wr_cur[i]);
                    n_pkts++;
                    in_wr = 0;
                    wr_cur.delete();
                end
            end
        end
    end

    byte unsigned log_d[$];
    bit           log_p[$];
    int           n_ovf = 0, n_runt = 0;

    initial forever begin
        @(negedge CLK);
        check("ena_out", ENA_OUT, exp_ena);
        check("psync_out", PSYNC_OUT, exp_psync);
        if (exp_ena != 0) check("data_out", DATA_OUT, exp_data);
        check("overflow", OVERFLOW, exp_ovf);
        check("runt", RUNT, exp_runt);
        if (ENA_OUT) begin
            log_d.push_back(DATA_OUT);
            log_p.push_back(PSYNC_OUT);
        end
        if (OVERFLOW) n_ovf++;
        if (RUNT) n_runt++;
    end

    int strobe_mode = 0;
    int density = 100;
    initial forever begin
        @(posedge CLK);
        #1;
        case (strobe_mode)
            1:       BYTE_STROBE = 1'b1;
            2:       BYTE_STROBE = ($urandom_range(99) < density);
            default: BYTE_STROBE = 1'b0;
        endcase
    end

    task automatic do_reset();
        @(negedge CLK);
        RST = 1'b1; ENA_IN = 1'b0; PSYNC_IN = 1'b0;
        @(negedge CLK);
        check("rst_data", DATA_OUT, 0);
        check("rst_ena", ENA_OUT, 0);
        check("rst_psync", PSYNC_OUT, 0);
        check("rst_ovf", OVERFLOW, 0);
        check("rst_runt", RUNT, 0);
        log_d.delete(); log_p.delete();
        n_ovf = 0; n_runt = 0;
        RST = 1'b0;
    endtask

    task automatic send_pkt(input int seed, input int cut_at, input int gap_pct);
        for (int i = 0; i < PL; i++) begin
            if (cut_at >= 0 && i == cut_at) break;
            while (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
                @(negedge CLK);
                ENA_IN = 1'b0; PSYNC_IN = 1'b0;
            end
            @(negedge CLK);
            ENA_IN = 1'b1;
            PSYNC_IN = (i == 0);
            DATA_IN = 8'(pkt_byte(seed, i));
        end
        @(negedge CLK);
        ENA_IN = 1'b0; PSYNC_IN = 1'b0;
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge CLK);
    endtask

    initial begin
        wait_cyc(3);

        // idle input: two null packets
        do_reset();
        strobe_mode = 1;
        wait_cyc(380);
        strobe_mode = 0;
        check("s1_len", int'(log_d.size() >= 2 * PL), 1);
        check("s1_b0", log_d[0], 'h47);
        check("s1_b1", log_d[1], 'h1F);
        check("s1_b2", log_d[2], 'hFF);
        check("s1_b3", log_d[3], 'h10);
        check("s1_b4", log_d[4], 'hFF);
        check("s1_b187", log_d[187], 'hFF);
        check("s1_b188", log_d[188], 'h47);
        check("s1_p0", log_p[0], 1);
        check("s1_p187", log_p[187], 0);
        check("s1_p188", log_p[188], 1);

        // single packet, then a null follows
        do_reset();
        send_pkt(0, -1, 0);
        strobe_mode = 1;
        wait_cyc(400);
        strobe_mode = 0;
        check("s2_b0", log_d[0], 'h47);
        check("s2_b1", log_d[1], 'h40);
        check("s2_b2", log_d[2], 'h00);
        check("s2_b3", log_d[3], 'h10);
        check("s2_b100", log_d[100], 100);
        check("s2_b187", log_d[187], 187);
        check("s2_p0", log_p[0], 1);
        check("s2_null_b189", log_d[189], 'h1F);
        check("s2_p188", log_p[188], 1);

        // packet committed mid-null waits for the boundary
        do_reset();
        fork
            send_pkt(7, -1, 0);
        join_none
        wait_cyc(138);
        strobe_mode = 1;
        wait_cyc(3 * PL + 10);
        strobe_mode = 0;
        check("s3_null_b1", log_d[1], 'h1F);
        check("s3_null_b187", log_d[187], 'hFF);
        check("s3_pkt_b1", log_d[189], 'h40);
        check("s3_pkt_b4", log_d[192], 11);
        check("s3_pkt_p", log_p[188], 1);

        // overflow: fifth packet dropped, four read in order
        do_reset();
        for (int k = 0; k < 5; k++) send_pkt(k * 16, -1, 0);
        check("s4_ovf_cnt", n_ovf, 1);
        strobe_mode = 1;
        wait_cyc(6 * PL + 20);
        strobe_mode = 0;
        for (int k = 0; k < 4; k++) check("s4_order", log_d[k * PL + 4], (k * 16 + 4) & 255);
        check("s4_then_null", log_d[4 * PL + 1], 'h1F);

        // runt at byte 100, following packet intact
        do_reset();
        send_pkt(3, 100, 0);
        send_pkt(9, -1, 0);
        check("s5_runt_cnt", n_runt, 1);
        strobe_mode = 1;
        wait_cyc(400);
        strobe_mode = 0;
        check("s5_b1", log_d[1], 'h40);
        check("s5_b4", log_d[4], 13);
        check("s5_next_null", log_d[PL + 1], 'h1F);

        // reset in the middle of a real packet
        do_reset();
        send_pkt(1, -1, 0);
        send_pkt(2, -1, 0);
        strobe_mode = 1;
        wait_cyc(61);
        do_reset();
        wait_cyc(400);
        strobe_mode = 0;
        check("s6_null0", log_d[1], 'h1F);
        check("s6_null1", log_d[PL + 1], 'h1F);

        // randomized traffic, model compares every cycle
        do_reset();
        strobe_mode = 2;
        for (int it = 0; it < 70; it++) begin
            case ((it / 10) % 4)
                0: density = 100;
                1: density = 90;
                2: density = 60;
                default: density = 30;
            endcase
            if ($urandom_range(7) == 0) begin
                @(negedge CLK);
                ENA_IN = 1'b1; PSYNC_IN = 1'b0; DATA_IN = 8'($urandom_range(255));
                @(negedge CLK);
                ENA_IN = 1'b0;
            end
            wait_cyc($urandom_range(40));
            send_pkt($urandom_range(255),
                     ($urandom_range(9) == 0) ? int'($urandom_range(1, 187)) : -1,
                     ($urandom_range(1) == 0) ? 0 : 20);
        end
        strobe_mode = 1;
        wait_cyc(1000);
        strobe_mode = 0;
        wait_cyc(5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ts_null_stuffer.md
# ts_null_stuffer

Constant-rate output stage downstream of the T2-MI packer. It buffers the packer's 188-byte T2-MI-over-TS packets, which arrive in bursts, and re-emits them on a fixed byte-slot schedule set by `BYTE_STROBE`. Whenever no complete packet is buffered at a packet boundary, it inserts a null packet (PID 0x1FFF), so the ASI/SPI transmitter always gets an unbroken packet stream.

## Interface
Parameters:
- `PKT_DEPTH`, default 4: buffer capacity in whole packets; byte RAM depth is `PKT_DEPTH`*188.

Ports:
- `CLK`  in  1  single clock, shared with the packer (`TS_DCLK_IN` domain).
- `RST`  in  1  reset; synchronous, active-high.
- `DATA_IN`  in  8  packet byte from packer.
- `ENA_IN`  in  1  `DATA_IN` valid this cycle.
- `PSYNC_IN`  in  1  qualifies first byte (0x47) of a packet; only meaningful with `ENA_IN`.
- `BYTE_STROBE`  in  1  output slot request; one output byte per strobe.
- `DATA_OUT`  out  8  output byte.
- `ENA_OUT`  out  1  `DATA_OUT` valid.
- `PSYNC_OUT`  out  1  first byte of output packet.
- `OVERFLOW`  out  1  one-cycle pulse: an incoming packet was dropped for lack of space.
- `RUNT`  out  1  one-cycle pulse: a partial packet was discarded.

## Operation
- Write side:
  - Byte counter `wcnt` runs 0..187. `ENA_IN` bytes seen before the first `PSYNC_IN` are ignored.
  - On an `ENA_IN` byte with `PSYNC_IN`, check free space = depth − (committed bytes + bytes being read).
    - If free ≥ 188: start writing at the commit pointer.
    - Else: drop every byte up to the next `PSYNC_IN` and pulse `OVERFLOW`.
  - Write pointer `wptr` advances per stored byte and wraps modulo `PKT_DEPTH`*188, which is not a power of two; wrap uses an explicit compare.
  - Storing byte 187 commits the packet: `cptr` ← `wptr`+1 and `pkt_cnt`++.
  - `PSYNC_IN` arriving with `wcnt`≠0 means a runt: `wptr` ← `cptr`, pulse `RUNT`, and treat this byte as a new packet start (same space check).
- Read side FSM, states `IDLE`, `SEND_PKT`, `SEND_NULL`:
  - `IDLE`: on `BYTE_STROBE`, if `pkt_cnt`>0 go to `SEND_PKT` and `pkt_cnt`--; else go to `SEND_NULL`. The first byte is output on that same strobe.
  - `SEND_PKT`: one buffered byte per strobe from `rptr`; after byte 187 return to `IDLE`.
  - `SEND_NULL`: byte sequence 0x47, 0x1F, 0xFF, 0x10, then 184 × 0xFF; after byte 187 return to `IDLE`.
  - The packet decision is made only at a boundary; a packet committed mid-null waits for the next boundary.
- Simultaneous `pkt_cnt` increment (commit) and decrement (read start) leave it unchanged.
- Space reserved for the packet being read is released per byte as `rptr` advances.

## Timing
- `BYTE_STROBE` in cycle n produces `DATA_OUT`/`ENA_OUT`=1 in cycle n+1 (registered RAM read); `ENA_OUT`=0 otherwise.
- `PSYNC_OUT`=1 together with byte 0 of every output packet, real or null.
- Store-to-available latency: a packet is eligible at the first boundary strobe at least 1 cycle after its byte 187 was written.
- `BYTE_STROBE` may be continuous (1 byte/cycle) or sparse; strobes in consecutive cycles are legal.
- Reset values: `DATA_OUT`=0x00, `ENA_OUT`=0, `PSYNC_OUT`=0, `OVERFLOW`=0, `RUNT`=0. Reset also clears FSM to `IDLE`, pointers/counters to 0, and the "seen sync" flag.
- Reset mid-operation: the in-progress output packet is truncated and all buffered data is discarded. The first strobe after reset starts a null packet unless a full packet has been committed since.

## Configuration
- `NULL_STUFF_STAT_EN` defined:
  - Adds output `NULL_CNT`[15:0], counting null packets started.
  - Adds output `DROP_CNT`[15:0], counting `OVERFLOW` plus `RUNT` events.
  - Both counters saturate at 0xFFFF and are cleared by `RST`.
- Not defined: these ports and counters are absent; behaviour is otherwise identical.

## Test plan
- No input, strobe continuous for 376 cycles -> two null packets; bytes 0..3 = 47 1F FF 10, rest FF; `PSYNC_OUT` at output bytes 0 and 188.
- One 188-byte packet (47 40 00 10, incrementing payload) written, then continuous strobe -> byte-exact copy; `PSYNC_OUT` on first byte; a null packet follows.
- Packet committed while a null is 50 bytes in -> null completes all 188 bytes, then the packet follows with no gap.
- `PKT_DEPTH`=4, five packets written with no strobes -> fifth dropped, one `OVERFLOW` pulse; then four real packets read out in order, then nulls.
- `PSYNC_IN` at input byte 100 of a packet -> `RUNT` pulse; partial packet never output; the following packet is output intact.
- `RST` asserted during `SEND_PKT` byte 60 with 2 packets buffered -> next cycle all outputs 0; subsequent strobes give null packets only.
